// File: rtl/mem_request_unit.sv
// ---------------------------------------------------------------------------
// mem_request_unit
//   MEM-stage data-side request controller. Takes the load/store/halt controls
//   held in EX/MEM and issues one data-cache access per memory instruction.
//   The request is held until the cache answers with dhit. While the access is
//   outstanding, the unit stalls the pipeline and blocks instruction fetch. It
//   also owns the sticky processor halt and a wait watchdog.
//
// Ports
//   CLK, nRST               clock / asynchronous active-low reset
//   mem_valid               EX/MEM holds a real (non-bubble) instruction
//   memren, memwen, halt    decoded load / store / HALT controls
//   addr, wdata             effective address and store data
//   dhit, dmemload          cache completion strobe and read data
//   dmemREN, dmemWEN        data read / write request (registered)
//   dmemaddr, dmemstore     latched data address / store data (registered)
//   imemREN                 instruction fetch enable
//   rdata                   load result to MEM/WB (registered)
//   mem_stall               freeze IF..EX/MEM latches
//   halt_out                sticky halt
//   timeout_err             sticky watchdog error (MAX_WAIT cycles without dhit)
// ---------------------------------------------------------------------------
module mem_request_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        mem_valid,
  input  logic        memren,
  input  logic        memwen,
  input  logic        halt,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        imemREN,
  output logic [31:0] rdata,
  output logic        mem_stall,
  output logic        halt_out,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DREQ   = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             start_s;
  logic             mem_stall_s;
  logic             imem_ren_s;
  logic             dmem_ren_r;
  logic             dmem_wen_r;
  logic [31:0]      dmem_addr_r;
  logic [31:0]      dmem_store_r;
  logic [31:0]      rdata_r;
  logic             halt_out_r;
  logic             timeout_err_r;
  logic [CNT_W-1:0] wait_cnt_r;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode plus the combinational stall / fetch-enable outputs.
  // The stall must rise in the same cycle a memory request is accepted so
  // that EX/MEM does not advance past it.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    mem_stall_s  = 1'b0;
    imem_ren_s   = 1'b0;
    case (state_r)
      IDLE: begin
        imem_ren_s = 1'b1;
        if (mem_valid && halt) begin
          state_next_s = HALTED;
        end else if (mem_valid && (memren || memwen)) begin
          state_next_s = DREQ;
          start_s      = 1'b1;
          mem_stall_s  = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      DREQ: begin
        mem_stall_s = 1'b1;
        if (dhit) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DREQ;
        end
      end
      DONE: begin
        imem_ren_s   = 1'b1;
        state_next_s = IDLE;
      end
      HALTED: begin
        mem_stall_s  = 1'b1;
        state_next_s = HALTED;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Request latch: address, store data and request type are captured on
  // acceptance. The enables are held until dhit. A read wins when both
  // controls are set.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dmem_ren_r   <= 1'b0;
      dmem_wen_r   <= 1'b0;
      dmem_addr_r  <= 32'h0000_0000;
      dmem_store_r <= 32'h0000_0000;
    end else if (start_s) begin
      dmem_ren_r   <= memren;
      dmem_wen_r   <= memwen & ~memren;
      dmem_addr_r  <= addr;
      dmem_store_r <= wdata;
    end else if ((state_r == DREQ) && !dhit) begin
      dmem_ren_r   <= dmem_ren_r;
      dmem_wen_r   <= dmem_wen_r;
    end else begin
      dmem_ren_r   <= 1'b0;
      dmem_wen_r   <= 1'b0;
    end
  end

  // Load result: captured only when a read completes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rdata_r <= 32'h0000_0000;
    end else if ((state_r == DREQ) && dhit && dmem_ren_r) begin
      rdata_r <= dmemload;
    end
  end

  // Wait watchdog: counts DREQ cycles without dhit and saturates at MAX_WAIT.
  // The error flag is sticky until reset. The access itself keeps waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt_r    <= CNT_ZERO;
      timeout_err_r <= 1'b0;
    end else if (start_s) begin
      wait_cnt_r    <= CNT_ZERO;
    end else if ((state_r == DREQ) && !dhit) begin
      if (wait_cnt_r != MAX_WAIT_C) begin
        wait_cnt_r <= wait_cnt_r + CNT_ONE;
      end
      if (wait_cnt_r >= (MAX_WAIT_C - CNT_ONE)) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  // Sticky halt flag: set on entry to HALTED; only reset clears it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halt_out_r <= 1'b0;
    end else if (state_next_s == HALTED) begin
      halt_out_r <= 1'b1;
    end
  end

  assign dmemREN     = dmem_ren_r;
  assign dmemWEN     = dmem_wen_r;
  assign dmemaddr    = dmem_addr_r;
  assign dmemstore   = dmem_store_r;
  assign rdata       = rdata_r;
  assign halt_out    = halt_out_r;
  assign timeout_err = timeout_err_r;
  assign mem_stall   = mem_stall_s;
  assign imemREN     = imem_ren_s;

endmodule
